// File: rtl/spn_pkg.sv
// Shared opcodes, scheduler states and request payload for the SPN request front-end.
package spn_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_ENC = 2'b01;
    localparam logic [1:0] OP_DEC = 2'b10;
    localparam logic [1:0] OP_ERR = 2'b11;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned KEY_W     = 32;
    // Tag field is sized for the widest tag any instance may use.
    localparam int unsigned TAG_MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ISSUE,
        CAPTURE
    } sched_state_e;

    typedef struct packed {
        logic [1:0]           op;
        logic [DATA_W-1:0]    data;
        logic [KEY_W-1:0]     key;
        logic [TAG_MAX_W-1:0] tag;
    } spn_req_t;

    function automatic logic op_is_legal(input logic [1:0] op);
        return (op == OP_ENC) || (op == OP_DEC);
    endfunction

endpackage

// File: rtl/spn_req_fifo.sv
// Synchronous request FIFO with registered occupancy; pointers wrap modulo DEPTH.
module spn_req_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/spn_req_scheduler.sv
// Request front-end for the SPN cipher unit: queues requests, sequences key/opcode
// timing to the unit and returns tagged responses over valid/ready.
module spn_req_scheduler
    import spn_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [DATA_W-1:0] req_data_i,
    input  logic [KEY_W-1:0]  req_key_i,
    input  logic [TAG_W-1:0]  req_tag_i,
    output logic [1:0]        cu_opcode_o,
    output logic [DATA_W-1:0] cu_in_data_o,
    output logic [KEY_W-1:0]  cu_key_o,
    input  logic [DATA_W-1:0] cu_out_data_i,
    input  logic [1:0]        cu_valid_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic [1:0]        rsp_status_o,
    output logic [TAG_W-1:0]  rsp_tag_o
);

    spn_req_t          push_req;
    spn_req_t          head_req;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;

    sched_state_e      state_q;
    logic              key_loaded_q;
    logic [1:0]        cu_opcode_q;
    logic [DATA_W-1:0] cu_in_data_q;
    logic [KEY_W-1:0]  cu_key_q;
    logic [1:0]        work_op_q;
    logic [DATA_W-1:0] work_data_q;
    logic [TAG_W-1:0]  work_tag_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [1:0]        rsp_status_q;
    logic [TAG_W-1:0]  rsp_tag_q;

    assign push_req = '{op: req_op_i, data: req_data_i, key: req_key_i,
                        tag: TAG_MAX_W'(req_tag_i)};

    spn_req_fifo #(
        .WIDTH ($bits(spn_req_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (req_valid_i),
        .push_data_i (push_req),
        .pop_i       (pop),
        .head_o      (head_req),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // A held response blocks the next pop, giving one bubble after each handshake.
    assign pop         = (state_q == IDLE) && !fifo_empty && !rsp_valid_q;
    assign req_ready_o = !fifo_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            key_loaded_q <= 1'b0;
            cu_opcode_q  <= OP_NOP;
            cu_in_data_q <= '0;
            cu_key_q     <= '0;
            work_op_q    <= OP_NOP;
            work_data_q  <= '0;
            work_tag_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= OP_NOP;
            rsp_tag_q    <= '0;
        end else begin
            if (rsp_valid_q && rsp_ready_i) rsp_valid_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        work_op_q   <= head_req.op;
                        work_data_q <= head_req.data;
                        work_tag_q  <= TAG_W'(head_req.tag);
                        if (!op_is_legal(head_req.op)) begin
                            rsp_valid_q  <= 1'b1;
                            rsp_data_q   <= '0;
                            rsp_status_q <= OP_ERR;
                            rsp_tag_q    <= TAG_W'(head_req.tag);
                        end else if (key_loaded_q && (head_req.key == cu_key_q)) begin
                            // Round keys already settled: present the opcode right away.
                            cu_opcode_q  <= head_req.op;
                            cu_in_data_q <= head_req.data;
                            state_q      <= ISSUE;
                        end else begin
                            cu_key_q     <= head_req.key;
                            key_loaded_q <= 1'b1;
                            state_q      <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    cu_opcode_q  <= work_op_q;
                    cu_in_data_q <= work_data_q;
                    state_q      <= ISSUE;
                end
                ISSUE: begin
                    cu_opcode_q <= OP_NOP;
                    state_q     <= CAPTURE;
                end
                CAPTURE: begin
                    rsp_valid_q  <= 1'b1;
                    rsp_data_q   <= cu_out_data_i;
                    rsp_tag_q    <= work_tag_q;
                    rsp_status_q <= (cu_valid_i == work_op_q) ? work_op_q : OP_ERR;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cu_opcode_o  = cu_opcode_q;
    assign cu_in_data_o = cu_in_data_q;
    assign cu_key_o     = cu_key_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_status_o = rsp_status_q;
    assign rsp_tag_o    = rsp_tag_q;

endmodule

// File: tb/tb_spn_req_scheduler.sv
// Scoreboard bench for spn_req_scheduler with a behavioural registered cipher unit.
module tb_spn_req_scheduler;
    import spn_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;

    localparam logic [31:0] K1 = 32'hA5A5_3C3C;
    localparam logic [31:0] KA = 32'h1111_2222;
    localparam logic [31:0] KB = 32'h3333_4444;
    localparam logic [31:0] K3 = 32'h5555_6666;

    typedef struct {
        logic [15:0]      d;
        logic [1:0]       s;
        logic [TAG_W-1:0] t;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid, req_ready;
    logic [1:0]       req_op;
    logic [15:0]      req_data;
    logic [31:0]      req_key;
    logic [TAG_W-1:0] req_tag;
    logic [1:0]       cu_opcode;
    logic [15:0]      cu_in_data;
    logic [31:0]      cu_key;
    logic [15:0]      cu_out_data;
    logic [1:0]       cu_valid;
    logic             rsp_valid, rsp_ready;
    logic [15:0]      rsp_data;
    logic [1:0]       rsp_status;
    logic [TAG_W-1:0] rsp_tag;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic fault_enc = 1'b0;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    spn_req_scheduler #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_op_i      (req_op),
        .req_data_i    (req_data),
        .req_key_i     (req_key),
        .req_tag_i     (req_tag),
        .cu_opcode_o   (cu_opcode),
        .cu_in_data_o  (cu_in_data),
        .cu_key_o      (cu_key),
        .cu_out_data_i (cu_out_data),
        .cu_valid_i    (cu_valid),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_data_o    (rsp_data),
        .rsp_status_o  (rsp_status),
        .rsp_tag_o     (rsp_tag)
    );

    function automatic logic [15:0] ref_enc(input logic [15:0] d, input logic [31:0] k);
        logic [15:0] x;
        x = d ^ k[15:0];
        return {x[12:0], x[15:13]} ^ k[31:16];
    endfunction

    function automatic logic [15:0] ref_dec(input logic [15:0] c, input logic [31:0] k);
        logic [15:0] x;
        x = c ^ k[31:16];
        return {x[2:0], x[15:3]} ^ k[15:0];
    endfunction

    // Cipher unit: round keys register the key input; result registers the opcode cycle.
    logic [31:0] rk_q;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rk_q        <= '0;
            cu_out_data <= '0;
            cu_valid    <= OP_NOP;
        end else begin
            rk_q        <= cu_key;
            cu_out_data <= (cu_opcode == OP_ENC) ? ref_enc(cu_in_data, rk_q) :
                           (cu_opcode == OP_DEC) ? ref_dec(cu_in_data, rk_q) : 16'h0000;
            cu_valid    <= (fault_enc && cu_opcode == OP_ENC) ? OP_ERR : cu_opcode;
        end
    end

    // Response monitor: every accepted response is checked against the scoreboard.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got tag=%0d data=%h, required no response", rsp_tag, rsp_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rsp_data, rsp_status, rsp_tag} !== {mon_e.d, mon_e.s, mon_e.t}) begin
                    n_fail++;
                    $display("FAIL rsp_payload: got data=%h status=%0d tag=%0d, required data=%h status=%0d tag=%0d",
                             rsp_data, rsp_status, rsp_tag, mon_e.d, mon_e.s, mon_e.t);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] d, input logic [31:0] k,
                        input logic [TAG_W-1:0] t);
        exp_t e;
        int   g;
        req_op = op; req_data = d; req_key = k; req_tag = t; req_valid = 1'b1;
        g = 0;
        while (req_ready !== 1'b1 && g < 300) begin
            step();
            g++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_accept tag=%0d: req_ready=%b, required 1", t, req_ready);
            req_valid = 1'b0;
            return;
        end
        step();
        e.t = t;
        if (op != OP_ENC && op != OP_DEC) begin
            e.d = 16'h0000;
            e.s = OP_ERR;
        end else begin
            e.d = (op == OP_ENC) ? ref_enc(d, k) : ref_dec(d, k);
            e.s = (fault_enc && op == OP_ENC) ? OP_ERR : op;
        end
        exp_q.push_back(e);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int lat, input string name);
        for (int k = 1; k <= lat; k++) begin
            step();
            n_checks++;
            if (k < lat && rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_early: rsp_valid=%b after %0d edges, required 0", name, rsp_valid, k);
            end else if (k == lat && rsp_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_latency: rsp_valid=%b after %0d edges, required 1", name, rsp_valid, k);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_op = OP_NOP; req_data = '0; req_key = '0;
        req_tag = '0; rsp_ready = 1'b1;
        step(); step();
        n_checks++;
        if ({req_ready, cu_opcode, cu_in_data, cu_key, rsp_valid, rsp_data, rsp_status, rsp_tag}
            !== {1'b1, OP_NOP, 16'h0, 32'h0, 1'b0, 16'h0, OP_NOP, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%b op=%0d in=%h key=%h rv=%b rd=%h rs=%0d rt=%0d, required 1 0 0000 00000000 0 0000 0 0",
                     req_ready, cu_opcode, cu_in_data, cu_key, rsp_valid, rsp_data, rsp_status, rsp_tag);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_round_trip();
        send(OP_ENC, 16'h1234, K1, 4'd1);
        step();
        n_checks++;
        if (cu_key !== K1 || cu_opcode !== OP_NOP) begin
            n_fail++;
            $display("FAIL rt_load: key=%h op=%0d, required key=%h op=0", cu_key, cu_opcode, K1);
        end
        step();
        n_checks++;
        if (cu_opcode !== OP_ENC || cu_in_data !== 16'h1234) begin
            n_fail++;
            $display("FAIL rt_issue: op=%0d in=%h, required op=1 in=1234", cu_opcode, cu_in_data);
        end
        step();
        n_checks++;
        if (cu_opcode !== OP_NOP || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rt_capture: op=%0d rv=%b, required op=0 rv=0", cu_opcode, rsp_valid);
        end
        step();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_status !== OP_ENC || rsp_tag !== 4'd1) begin
            n_fail++;
            $display("FAIL rt_enc_rsp: rv=%b st=%0d tag=%0d, required 1 1 1", rsp_valid, rsp_status, rsp_tag);
        end
        step();
        send(OP_DEC, ref_enc(16'h1234, K1), K1, 4'd2);
        step();
        n_checks++;
        if (cu_opcode !== OP_DEC) begin
            n_fail++;
            $display("FAIL rt_no_load: op=%0d one edge after handshake, required 2", cu_opcode);
        end
        wait_rsp(2, "rt_dec");
        n_checks++;
        if (rsp_data !== 16'h1234 || rsp_status !== OP_DEC) begin
            n_fail++;
            $display("FAIL rt_dec_data: data=%h st=%0d, required 1234 2", rsp_data, rsp_status);
        end
        step();
    endtask

    task automatic test_illegal_op();
        logic [1:0] ops[2];
        ops[0] = OP_NOP;
        ops[1] = OP_ERR;
        for (int i = 0; i < 2; i++) begin
            send(ops[i], 16'hFFFF, KB, 4'(5 + i));
            step();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 16'h0 || rsp_status !== OP_ERR ||
                rsp_tag !== 4'(5 + i) || cu_opcode !== OP_NOP || cu_key !== K1) begin
                n_fail++;
                $display("FAIL illegal_rsp: rv=%b d=%h st=%0d tag=%0d op=%0d key=%h, required 1 0000 3 %0d 0 %h",
                         rsp_valid, rsp_data, rsp_status, rsp_tag, cu_opcode, cu_key, 5 + i, K1);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < DEPTH + 2; i++)
                    send(OP_ENC, 16'h0100 + 16'(i), K1, 4'(6 + i));
            end
            begin
                logic        held;
                logic        hold_bad;
                logic        op_bad;
                logic [15:0] held_data;
                held = 1'b0; hold_bad = 1'b0; op_bad = 1'b0; held_data = '0;
                for (int c = 0; c < 25; c++) begin
                    step();
                    if (held && (rsp_valid !== 1'b1 || rsp_data !== held_data || rsp_tag !== 4'd6))
                        hold_bad = 1'b1;
                    if (rsp_valid === 1'b1 && cu_opcode !== OP_NOP) op_bad = 1'b1;
                    if (!held && rsp_valid === 1'b1) begin
                        held = 1'b1;
                        held_data = rsp_data;
                    end
                end
                n_checks++;
                if (!held || hold_bad || rsp_tag !== 4'd6) begin
                    n_fail++;
                    $display("FAIL bp_hold: held=%b unstable=%b tag=%0d, required 1 0 6", held, hold_bad, rsp_tag);
                end
                n_checks++;
                if (op_bad) begin
                    n_fail++;
                    $display("FAIL bp_cu_idle: cu_opcode active while response held, required idle");
                end
                n_checks++;
                if (req_ready !== 1'b0 || exp_q.size() != DEPTH + 1) begin
                    n_fail++;
                    $display("FAIL bp_full: req_ready=%b accepted=%0d, required 0 %0d", req_ready, exp_q.size(), DEPTH + 1);
                end
                rsp_ready = 1'b1;
            end
        join
        for (int g = 0; g < 200 && exp_q.size() != 0; g++) step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_key_alternation();
        logic [15:0] pts[4];
        logic [31:0] k;
        pts[0] = 16'h0000; pts[1] = 16'hFFFF; pts[2] = 16'h5AA5; pts[3] = 16'hC001;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 4; i++) begin
                k = (i % 2 == 0) ? KA : KB;
                if (pass == 0) send(OP_ENC, pts[i], k, 4'(i));
                else           send(OP_DEC, ref_enc(pts[i], k), k, 4'(8 + i));
                wait_rsp(4, "alt_key");
                if (pass == 1) begin
                    n_checks++;
                    if (rsp_data !== pts[i]) begin
                        n_fail++;
                        $display("FAIL alt_roundtrip %0d: data=%h, required %h", i, rsp_data, pts[i]);
                    end
                end
                step();
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic hit;
        logic stale;
        rsp_ready = 1'b0;
        send(OP_NOP, 16'h0, K3, 4'd15);
        for (int i = 0; i < 4; i++) send(OP_ENC, 16'h2000 + 16'(i), K3, 4'(1 + i));
        rsp_ready = 1'b1;
        hit = 1'b0;
        for (int g = 0; g < 20 && !hit; g++) begin
            step();
            if (cu_opcode !== OP_NOP) hit = 1'b1;
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL mid_issue: cu_opcode never left NOP, required ISSUE");
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({req_ready, cu_opcode, cu_in_data, cu_key, rsp_valid, rsp_data, rsp_status, rsp_tag}
            !== {1'b1, OP_NOP, 16'h0, 32'h0, 1'b0, 16'h0, OP_NOP, 4'h0}) begin
            n_fail++;
            $display("FAIL mid_reset_values: rdy=%b op=%0d in=%h key=%h rv=%b rd=%h rs=%0d rt=%0d, required reset values",
                     req_ready, cu_opcode, cu_in_data, cu_key, rsp_valid, rsp_data, rsp_status, rsp_tag);
        end
        exp_q.delete();
        step(); step();
        reset = 1'b0;
        stale = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (rsp_valid !== 1'b0 || cu_opcode !== OP_NOP) stale = 1'b1;
        end
        n_checks++;
        if (stale) begin
            n_fail++;
            $display("FAIL mid_stale: activity after reset release, required none");
        end
        send(OP_ENC, 16'hBEEF, K3, 4'd3);
        wait_rsp(4, "post_reset");
        step();
    endtask

    task automatic test_faulty_unit();
        fault_enc = 1'b1;
        send(OP_ENC, 16'h0F0F, K3, 4'd9);
        wait_rsp(3, "fault_enc");
        n_checks++;
        if (rsp_status !== OP_ERR || rsp_tag !== 4'd9) begin
            n_fail++;
            $display("FAIL fault_status: st=%0d tag=%0d, required 3 9", rsp_status, rsp_tag);
        end
        step();
        send(OP_DEC, 16'h0F0F, K3, 4'd10);
        wait_rsp(3, "fault_dec");
        n_checks++;
        if (rsp_status !== OP_DEC || rsp_tag !== 4'd10) begin
            n_fail++;
            $display("FAIL fault_dec_ok: st=%0d tag=%0d, required 2 10", rsp_status, rsp_tag);
        end
        step();
        fault_enc = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_trip();
        test_illegal_op();
        test_backpressure();
        test_key_alternation();
        test_reset_mid_op();
        test_faulty_unit();
        step(); step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_drain: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
